prescaled_mode_counter: RTL
===========================

PRESCALED_MODE_COUNTER -- requirements
Module: prescaled_mode_counter

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 4: width of count value.
REQ-002 SHALL have parameter MIN_VALUE, default 0: lower count bound.
REQ-003 SHALL have parameter MAX_VALUE, default 12: upper count bound; legal only if MIN_VALUE < MAX_VALUE <= 2^BIT_WIDTH-1.
REQ-004 SHALL have parameter PS_WIDTH, default 24: prescaler width.
REQ-005 SHALL have port i_clk  input  1: clock; all logic on rising edge.
REQ-006 SHALL have port i_rst_n  input  1: reset, asynchronous, active-low.
REQ-007 SHALL have port i_en  input  1: enable; low freezes prescaler and count.
REQ-008 SHALL have port i_clr  input  1: synchronous clear.
REQ-009 SHALL have port i_load  input  1: synchronous load strobe.
REQ-010 SHALL have port i_load_value  input  BIT_WIDTH: load data.
REQ-011 SHALL have port i_mode  input  2: 0 wrap, 1 saturate, 2 bounce, 3 hold.
REQ-012 SHALL have port i_dir  input  1: 0 up, 1 down; used in wrap/saturate only.
REQ-013 SHALL have port i_prescale  input  PS_WIDTH: step every i_prescale+1 enabled cycles.
REQ-014 SHALL have port o_count  output  BIT_WIDTH: registered count.
REQ-015 SHALL have port o_tick  output  1: one-cycle pulse, prescaler terminal reached.
REQ-016 SHALL have port o_tc  output  1: one-cycle terminal-event pulse.
REQ-017 SHALL have port o_dir  output  1: direction of last step (0 up, 1 down).
REQ-018 SHALL have ports o_at_max, o_at_min  output  1 each: o_count==MAX_VALUE / ==MIN_VALUE, combinational from o_count.

Function
REQ-019 SHALL evaluate per edge, priority: i_clr > i_load > step; lower-priority actions ignored that cycle.
REQ-020 i_clr SHALL set count=MIN_VALUE, prescaler=0, o_dir=0, o_tick=o_tc=0, regardless of i_en.
REQ-021 i_load SHALL set count=i_load_value clamped to [MIN_VALUE,MAX_VALUE], prescaler=0, o_tick=o_tc=0, regardless of i_en; o_dir unchanged.
REQ-022 Prescaler SHALL advance only when i_en=1; on enabled cycle with prescaler>=i_prescale, prescaler->0 and a step occurs; otherwise prescaler+1.
REQ-023 i_prescale=0 SHALL step every enabled cycle; o_count updates on the edge sampling i_en=1 (one-cycle latency).
REQ-024 o_tick SHALL be 1 for exactly the cycle after each step edge, also in hold mode; 0 otherwise.
REQ-025 Wrap up: count==MAX -> MIN with o_tc=1, else +1; wrap down: count==MIN -> MAX with o_tc=1, else -1; o_dir<=i_dir.
REQ-026 Saturate: up +1 stopping at MAX, down -1 stopping at MIN; o_tc=1 only on the step that lands on the bound; steps at bound hold count, o_tc=0; o_dir<=i_dir.
REQ-027 Bounce: moves per o_dir; step landing on MAX sets o_dir=1, step landing on MIN sets o_dir=0, o_tc=1 on both; step from bound moves away (sequence MIN..MAX..MIN, no repeated endpoints).
REQ-028 Bounce entered with count at a bound SHALL first step away from that bound irrespective of o_dir.
REQ-029 Hold: count, o_dir unchanged, o_tc=0; prescaler and o_tick keep running.
REQ-030 Mode/i_dir/i_prescale changes SHALL take effect at the next step/prescaler evaluation without resetting prescaler.
REQ-031 All arithmetic SHALL stay within [MIN_VALUE,MAX_VALUE]; no BIT_WIDTH overflow possible.

Reset
REQ-032 i_rst_n low SHALL asynchronously force count=MIN_VALUE, prescaler=0, o_dir=0, o_tick=0, o_tc=0.
REQ-033 After release, first step SHALL occur on the (i_prescale+1)th enabled edge.
REQ-034 Reset mid-count SHALL discard prescaler progress and bounce direction.

Verification (BIT_WIDTH=4, MIN=0, MAX=12)
REQ-035 Wrap up, i_prescale=0, i_en=1 for 14 cycles -> o_count 1..12,0,1; o_tc one pulse with o_count=0.
REQ-036 Saturate down, i_prescale=2, load 2 -> steps every 3rd cycle 1,0,0; o_tc once at 0; o_tick every 3rd cycle.
REQ-037 Bounce from 10, i_prescale=0 -> 11,12,11,10; o_dir 0,1,1,1; o_tc on reaching 12.
REQ-038 i_load_value=15 -> o_count=12; i_clr and i_load same cycle -> o_count=0.
REQ-039 i_en toggled low mid-prescale (i_prescale=4) -> step delayed by exactly the low cycles.
REQ-040 i_rst_n pulsed low between edges at count 7 -> o_count=0, o_dir=0 immediately, no clock required.

Source files
------------

// File: rtl/prescaled_mode_counter.sv
// Bounded up/down counter advanced by a programmable prescaler, with wrap,
// saturate, bounce and hold modes plus synchronous clear and clamped load.
module prescaled_mode_counter #(
    parameter int BIT_WIDTH = 4,
    parameter int MIN_VALUE = 0,
    parameter int MAX_VALUE = 12,
    parameter int PS_WIDTH  = 24
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_en,
    input  logic                 i_clr,
    input  logic                 i_load,
    input  logic [BIT_WIDTH-1:0] i_load_value,
    input  logic [1:0]           i_mode,
    input  logic                 i_dir,
    input  logic [PS_WIDTH-1:0]  i_prescale,
    output logic [BIT_WIDTH-1:0] o_count,
    output logic                 o_tick,
    output logic                 o_tc,
    output logic                 o_dir,
    output logic                 o_at_max,
    output logic                 o_at_min
);

    localparam logic [BIT_WIDTH-1:0] MIN_V = BIT_WIDTH'(MIN_VALUE);
    localparam logic [BIT_WIDTH-1:0] MAX_V = BIT_WIDTH'(MAX_VALUE);

    localparam logic [1:0] MODE_WRAP   = 2'd0;
    localparam logic [1:0] MODE_SAT    = 2'd1;
    localparam logic [1:0] MODE_BOUNCE = 2'd2;

    logic [BIT_WIDTH-1:0] count_reg, count_next;
    logic [PS_WIDTH-1:0]  ps_reg, ps_next;
    logic                 dir_reg, dir_next;
    logic                 tick_reg, tick_next;
    logic                 tc_reg, tc_next;

    logic                 at_max, at_min;
    logic [BIT_WIDTH-1:0] count_inc, count_dec;
    logic [BIT_WIDTH-1:0] step_count;
    logic                 step_dir, step_tc, bounce_down;
    logic                 load_below, load_above;
    logic [BIT_WIDTH-1:0] load_clamped;

    assign at_max    = (count_reg == MAX_V);
    assign at_min    = (count_reg == MIN_V);
    assign count_inc = count_reg + BIT_WIDTH'(1);
    assign count_dec = count_reg - BIT_WIDTH'(1);

    // Range checks that can never fire for this parameter set are tied off
    // so no always-true/false comparison is built.
    generate
        if (MIN_VALUE == 0) begin : g_lo_zero
            assign load_below = 1'b0;
        end else begin : g_lo_cmp
            assign load_below = (i_load_value < MIN_V);
        end
        if (MAX_VALUE == (2 ** BIT_WIDTH) - 1) begin : g_hi_full
            assign load_above = 1'b0;
        end else begin : g_hi_cmp
            assign load_above = (i_load_value > MAX_V);
        end
    endgenerate

    assign load_clamped = load_below ? MIN_V : (load_above ? MAX_V : i_load_value);

    always_comb begin
        step_count  = count_reg;
        step_dir    = dir_reg;
        step_tc     = 1'b0;
        bounce_down = 1'b0;
        case (i_mode)
            MODE_WRAP: begin
                step_dir = i_dir;
                if (!i_dir) begin
                    if (at_max) begin
                        step_count = MIN_V;
                        step_tc    = 1'b1;
                    end else begin
                        step_count = count_inc;
                    end
                end else begin
                    if (at_min) begin
                        step_count = MAX_V;
                        step_tc    = 1'b1;
                    end else begin
                        step_count = count_dec;
                    end
                end
            end
            MODE_SAT: begin
                step_dir = i_dir;
                if (!i_dir) begin
                    if (!at_max) begin
                        step_count = count_inc;
                        step_tc    = (count_inc == MAX_V);
                    end
                end else begin
                    if (!at_min) begin
                        step_count = count_dec;
                        step_tc    = (count_dec == MIN_V);
                    end
                end
            end
            MODE_BOUNCE: begin
                // A bound always pushes the count back inward, whatever o_dir says.
                bounce_down = at_max || (!at_min && dir_reg);
                if (bounce_down) begin
                    step_count = count_dec;
                    step_dir   = 1'b1;
                    if (count_dec == MIN_V) begin
                        step_dir = 1'b0;
                        step_tc  = 1'b1;
                    end
                end else begin
                    step_count = count_inc;
                    step_dir   = 1'b0;
                    if (count_inc == MAX_V) begin
                        step_dir = 1'b1;
                        step_tc  = 1'b1;
                    end
                end
            end
            default: begin
                step_count = count_reg;
            end
        endcase
    end

    always_comb begin
        count_next = count_reg;
        ps_next    = ps_reg;
        dir_next   = dir_reg;
        tick_next  = 1'b0;
        tc_next    = 1'b0;
        if (i_clr) begin
            count_next = MIN_V;
            ps_next    = '0;
            dir_next   = 1'b0;
        end else if (i_load) begin
            count_next = load_clamped;
            ps_next    = '0;
        end else if (i_en) begin
            if (ps_reg >= i_prescale) begin
                ps_next    = '0;
                tick_next  = 1'b1;
                count_next = step_count;
                dir_next   = step_dir;
                tc_next    = step_tc;
            end else begin
                ps_next = ps_reg + PS_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_reg <= MIN_V;
            ps_reg    <= '0;
            dir_reg   <= 1'b0;
            tick_reg  <= 1'b0;
            tc_reg    <= 1'b0;
        end else begin
            count_reg <= count_next;
            ps_reg    <= ps_next;
            dir_reg   <= dir_next;
            tick_reg  <= tick_next;
            tc_reg    <= tc_next;
        end
    end

    assign o_count  = count_reg;
    assign o_tick   = tick_reg;
    assign o_tc     = tc_reg;
    assign o_dir    = dir_reg;
    assign o_at_max = at_max;
    assign o_at_min = at_min;

endmodule
